// File: rtl/lvds_tx_frame_scheduler.sv
// -----------------------------------------------------------------------------
// lvds_tx_frame_scheduler
// Purpose : once per frame period, snapshots ten 16-bit channels and hands the
//           serializer one 37-bit word per channel over a valid/ready handshake.
//           Word layout: {parity, word_num[3:0], crc[15:0], data[15:0]}.
// Config  : define LVDS_TX_CRC_EN to build the CRC multiplier. Without it the
//           crc field is forced to zero (serializer bring-up only).
// Ports   : clk, rst_n            - clock, async active-low reset
//           enable                - allows frame ticks
//           data1..data10         - channel values
//           word_out/word_valid   - payload and valid to serializer
//           word_ready            - serializer accepts the word
//           frame_start           - pulse in the snapshot (LOAD) cycle
//           frame_done            - pulse after acceptance of word 10
//           overrun               - sticky, tick arrived during a frame
//           frames_sent           - completed frame count, wraps
// -----------------------------------------------------------------------------
module lvds_tx_frame_scheduler #(
    parameter int unsigned FRAME_PERIOD = 1600,
    parameter int unsigned WORD_GAP     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] data3,
    input  logic [15:0] data4,
    input  logic [15:0] data5,
    input  logic [15:0] data6,
    input  logic [15:0] data7,
    input  logic [15:0] data8,
    input  logic [15:0] data9,
    input  logic [15:0] data10,
    output logic [36:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overrun,
    output logic [15:0] frames_sent
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned GAP_W     = 32;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned WORD_W    = 37;
    localparam int unsigned NUM_WORDS = 10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CALC    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_k;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_snap [0:NUM_WORDS-1];
    logic [WORD_W-1:0] r_word_out;
    logic              r_word_valid;
    logic              r_frame_start;
    logic              r_frame_done;
    logic              r_overrun;
    logic [15:0]       r_frames_sent;

    logic [2:0]        w_state_next;
    logic [3:0]        w_k_next;
    logic [GAP_W-1:0]  w_gap_next;
    logic              w_tick;
    logic              w_load;
    logic              w_calc;
    logic              w_last;
    logic [DATA_W-1:0] w_data [0:NUM_WORDS-1];
    logic [DATA_W-1:0] w_snap_sel;
    logic [15:0]       w_crc;
    logic [35:0]       w_body;
    logic [WORD_W-1:0] w_word;

    assign w_data[0] = data1;
    assign w_data[1] = data2;
    assign w_data[2] = data3;
    assign w_data[3] = data4;
    assign w_data[4] = data5;
    assign w_data[5] = data6;
    assign w_data[6] = data7;
    assign w_data[7] = data8;
    assign w_data[8] = data9;
    assign w_data[9] = data10;

    // Period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(FRAME_PERIOD - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tick = enable && (r_cnt == '0);

    // Snapshot entry for the current word number (k is 1-based).
    always_comb begin
        w_snap_sel = '0;
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            if (r_k == 4'(i + 1)) begin
                w_snap_sel = r_snap[i];
            end
        end
    end

`ifdef LVDS_TX_CRC_EN
    localparam int unsigned CRC_MULT = 44111;
    logic [35:0] w_prod;
    logic        w_unused_prod_hi;

    assign w_prod = 36'({r_k, w_snap_sel}) * 36'(CRC_MULT);
    // crc = low 16 bits of p ^ (p >> 8); bits above 23 never reach it.
    assign w_crc  = w_prod[15:0] ^ w_prod[23:8];
    assign w_unused_prod_hi = ^w_prod[35:24];
`else
    assign w_crc = '0;
`endif

    assign w_body = {r_k, w_crc, w_snap_sel};
    assign w_word = {^w_body, w_body};

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_gap_next   = r_gap;
        w_load       = 1'b0;
        w_calc       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_k_next     = 4'd1;
                w_state_next = S_CALC;
            end
            S_CALC: begin
                w_calc       = 1'b1;
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (word_ready) begin
                    if (r_k == 4'(NUM_WORDS)) begin
                        w_last       = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (WORD_GAP > 0) begin
                        w_gap_next   = '0;
                        w_state_next = S_GAP;
                    end else begin
                        w_k_next     = r_k + 4'd1;
                        w_state_next = S_CALC;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(WORD_GAP - 1)) begin
                    w_k_next     = r_k + 4'd1;
                    w_state_next = S_CALC;
                end else begin
                    w_gap_next = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_gap         <= '0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frames_sent <= '0;
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state       <= w_state_next;
            r_k           <= w_k_next;
            r_gap         <= w_gap_next;
            // Pulses/levels are aligned with the state they describe.
            r_frame_start <= (w_state_next == S_LOAD);
            r_word_valid  <= (w_state_next == S_PRESENT);
            r_frame_done  <= w_last;
            r_frames_sent <= r_frames_sent + 16'(w_last);
            // A tick outside IDLE is dropped but remembered.
            r_overrun     <= r_overrun | (w_tick && (r_state != S_IDLE));
            if (w_calc) begin
                r_word_out <= w_word;
            end
            if (w_load) begin
                for (int i = 0; i < int'(NUM_WORDS); i++) begin
                    r_snap[i] <= w_data[i];
                end
            end
        end
    end

    assign word_out    = r_word_out;
    assign word_valid  = r_word_valid;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_lvds_tx_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lvds_tx_frame_scheduler
// Self-checking bench: table of frames (data, expected first word, expected
// frame count, handshake mode) plus hand sequences for overrun and async reset.
// Accepted words are compared against a scoreboard queue filled at each tick.
// -----------------------------------------------------------------------------
module tb_lvds_tx_frame_scheduler;

    localparam int unsigned FP = 64;

    typedef struct packed {
        logic [1:0]        mode;      // 0 full speed, 1 backpressure word 4, 2 snapshot change
        logic [9:0][15:0]  d;
        logic [36:0]       exp_w1;
        logic [15:0]       exp_sent;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [9:0][15:0] tb_d;
    logic [36:0]      word_out;
    logic             word_valid;
    logic             word_ready;
    logic             frame_start;
    logic             frame_done;
    logic             overrun;
    logic [15:0]      frames_sent;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q [$];
    bit prev_acc = 1'b0;

    lvds_tx_frame_scheduler #(.FRAME_PERIOD(FP), .WORD_GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .data1(tb_d[0]), .data2(tb_d[1]), .data3(tb_d[2]), .data4(tb_d[3]),
        .data5(tb_d[4]), .data6(tb_d[5]), .data7(tb_d[6]), .data8(tb_d[7]),
        .data9(tb_d[8]), .data10(tb_d[9]),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .frame_start(frame_start), .frame_done(frame_done),
        .overrun(overrun), .frames_sent(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference word: p = {k,data}*44111, crc = (p ^ p>>8)[15:0], parity over 35:0.
    function automatic logic [36:0] calc_word(input logic [3:0] k, input logic [15:0] d);
        logic [35:0] p;
        logic [35:0] c;
        logic [15:0] crc;
        logic [35:0] body;
`ifdef LVDS_TX_CRC_EN
        p   = 36'({k, d}) * 36'd44111;
        c   = p ^ (p >> 8);
        crc = c[15:0];
`else
        p   = '0;
        c   = p;
        crc = c[15:0];
`endif
        body = {k, crc, d};
        return {^body, body};
    endfunction

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    // Scoreboard: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) chk("valid_low_between_words", 37'(word_valid), 37'd0);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_word", $sformatf("extra word %h", word_out));
                else chk("word", word_out, exp_q.pop_front());
                prev_acc = 1'b1;
            end else begin
                prev_acc = 1'b0;
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int  t;
        int  held;
        int  exp_t;
        bit  done;
        logic [36:0] hold_val;
        held = 0; done = 1'b0; hold_val = '0;
        tb_d = v.d;
        word_ready = 1'b1;
        for (int k = 1; k <= 10; k++) exp_q.push_back(calc_word(4'(k), v.d[k-1]));
        enable = 1'b1;                                   // tick cycle T
        @(posedge clk); #1; enable = 1'b0;               // T+1
        chk("frame_start_T1", 37'(frame_start), 37'd1);
        chk("valid_T1", 37'(word_valid), 37'd0);
        @(posedge clk); #1;                              // T+2
        if (v.mode == 2'd2) tb_d[4] = 16'hABCD;
        chk("frame_start_T2", 37'(frame_start), 37'd0);
        chk("valid_T2", 37'(word_valid), 37'd0);
        @(posedge clk); #1;                              // T+3
        chk("valid_T3", 37'(word_valid), 37'd1);
        chk("first_word", word_out, v.exp_w1);
        for (t = 4; t <= 300; t++) begin
            @(posedge clk); #1;
            if (frame_done) begin done = 1'b1; break; end
            if (v.mode == 2'd1 && word_valid && word_out[35:32] == 4'd4) begin
                if (held == 0) hold_val = word_out;
                else chk("bp_hold", word_out, hold_val);
                held++;
                word_ready = (held > 50);
            end else begin
                word_ready = 1'b1;
            end
        end
        if (!done) begin
            fail_now("frame_done_timeout", "no frame_done within 300 cycles");
        end else begin
            exp_t = (v.mode == 2'd1) ? 72 : 22;
            chk("done_cycle", 37'(t), 37'(exp_t));
            chk("frames_sent", 37'(frames_sent), 37'(v.exp_sent));
            if (v.mode == 2'd1) chk("bp_cycles", 37'(held), 37'd51);
        end
        @(posedge clk); #1;
        chk("done_pulse_width", 37'(frame_done), 37'd0);
        chk("queue_drained", 37'(exp_q.size()), 37'd0);
    endtask

    vec_t vecs [5];
    vec_t v;
    bit   hit;
    bit   done;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Table
        for (int i = 0; i < 5; i++) begin
            vecs[i].mode     = 2'd0;
            vecs[i].exp_sent = 16'(i + 1);
            for (int j = 0; j < 10; j++) begin
                case (i)
                    0: vecs[i].d[j] = 16'h0000;
                    1: vecs[i].d[j] = 16'(j + 1);
                    2: vecs[i].d[j] = 16'hFFFF ^ 16'(j * 16'h1111);
                    3: vecs[i].d[j] = 16'h8000 >> j;
                    default: vecs[i].d[j] = 16'h0F00 + 16'(j);
                endcase
            end
        end
        vecs[3].mode = 2'd1;
        vecs[4].mode = 2'd2;
        vecs[4].d[4] = 16'h1234;
        for (int i = 0; i < 5; i++) vecs[i].exp_w1 = calc_word(4'd1, vecs[i].d[0]);
`ifdef LVDS_TX_CRC_EN
        vecs[0].exp_w1 = 37'h014F000000;
`else
        vecs[0].exp_w1 = 37'h1100000000;
`endif

        // Reset
        rst_n = 1'b0; enable = 1'b0; word_ready = 1'b0; tb_d = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_out", word_out, 37'd0);
        chk("rst_word_valid", 37'(word_valid), 37'd0);
        chk("rst_frame_start", 37'(frame_start), 37'd0);
        chk("rst_frame_done", 37'(frame_done), 37'd0);
        chk("rst_overrun", 37'(overrun), 37'd0);
        chk("rst_frames_sent", 37'(frames_sent), 37'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", 37'(frame_start), 37'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);
        chk("no_overrun_yet", 37'(overrun), 37'd0);

        // Overrun: second tick at T+64 while word 1 is stalled
        v = vecs[1];
        tb_d = v.d;
        word_ready = 1'b0;
        for (int k = 1; k <= 10; k++) exp_q.push_back(calc_word(4'(k), v.d[k-1]));
        enable = 1'b1;
        for (int c = 1; c <= 64; c++) begin @(posedge clk); #1; end
        chk("overrun_before_tick2", 37'(overrun), 37'd0);
        @(posedge clk); #1;
        enable = 1'b0;
        chk("overrun_set", 37'(overrun), 37'd1);
        chk("overrun_word_held", word_out, calc_word(4'd1, v.d[0]));
        chk("overrun_valid_held", 37'(word_valid), 37'd1);
        word_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (frame_done) begin done = 1'b1; break; end
        end
        if (!done) fail_now("overrun_frame_timeout", "frame did not complete");
        chk("overrun_frames_sent", 37'(frames_sent), 37'd6);
        repeat (5) @(posedge clk);
        #1;
        chk("dropped_tick_no_frame", 37'(word_valid), 37'd0);
        chk("overrun_sticky", 37'(overrun), 37'd1);
        chk("overrun_queue", 37'(exp_q.size()), 37'd0);

        // Async reset during PRESENT of word 7
        v = vecs[2];
        tb_d = v.d;
        word_ready = 1'b1;
        for (int k = 1; k <= 10; k++) exp_q.push_back(calc_word(4'(k), v.d[k-1]));
        enable = 1'b1;
        @(posedge clk); #1; enable = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (word_valid && word_out[35:32] == 4'd7) begin
                word_ready = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            fail_now("word7_timeout", "word 7 never presented");
            rst_n = 1'b0;
        end
        chk("arst_valid_drop", 37'(word_valid), 37'd0);
        chk("arst_word_out", word_out, 37'd0);
        chk("arst_frames_sent", 37'(frames_sent), 37'd0);
        chk("arst_overrun_clear", 37'(overrun), 37'd0);
        chk("arst_words_left", 37'(exp_q.size()), 37'd4);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = vecs[1];
        v.exp_sent = 16'd1;
        run_frame(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
